// File: rtl/error_gpack.sv
// Shared definitions for the error-checker / error-corrector slice.
//   ener_bitwidth       : default width of the flag energies
//   flag_code_t         : flag code for the default configuration (N = 4)
//   flag_none           : code meaning "no flag at this position"
//   flag_kind_e         : classification of a flag code against N
//   flag_kind()         : split a code into none / add / subtract / invalid
//   flag_pattern_index(): pattern number addressed by an add or subtract code
package error_gpack;

    localparam int unsigned ener_bitwidth      = 8;
    localparam int unsigned flag_code_bitwidth = 4;   // $clog2(2*4+1)
    localparam int unsigned sum_bitwidth_min   = 5;

    typedef logic [flag_code_bitwidth-1:0] flag_code_t;

    localparam flag_code_t flag_none = '0;

    typedef enum logic [1:0] {
        FLAG_KIND_NONE,
        FLAG_KIND_ADD,
        FLAG_KIND_SUB,
        FLAG_KIND_BAD
    } flag_kind_e;

    // Codes 1..n add pattern code-1, n+1..2n subtract pattern code-n-1.
    function automatic flag_kind_e flag_kind(input int unsigned code,
                                             input int unsigned n);
        if (code == 0)
            return FLAG_KIND_NONE;
        else if (code <= n)
            return FLAG_KIND_ADD;
        else if (code <= 2 * n)
            return FLAG_KIND_SUB;
        else
            return FLAG_KIND_BAD;
    endfunction

    // Only meaningful for add/subtract codes.
    function automatic int unsigned flag_pattern_index(input int unsigned code,
                                                       input int unsigned n);
        if (code <= n)
            return code - 1;
        else
            return code - n - 1;
    endfunction

endpackage

// File: rtl/flag_window_resolver.sv
// Greedy flag acceptance for one symbol word (purely combinational).
//   i_en_correct    : 0 -> nothing accepted and nothing counted as dropped
//   i_sd_flags      : flag code per position
//   i_sd_flags_ener : flag energy per position
//   i_ener_thresh   : largest energy still accepted
//   i_carry_claim   : positions 0..D-2 already claimed by the previous word
//   o_accept        : per-position accepted flag
//   o_drop          : per-position dropped (nonzero, not accepted) flag
//   o_claim_out     : claims spilling into positions 0..D-2 of the next word
//   o_num_accept    : number of accepted flags in this word
//   o_num_drop      : number of dropped flags in this word
module flag_window_resolver #(
    parameter int unsigned width                   = 16,
    parameter int unsigned num_of_trellis_patterns = 4,
    parameter int unsigned trellis_pattern_depth   = 4,
    parameter int unsigned ener_bitwidth           = 8,
    localparam int unsigned FLAG_W   = $clog2(2 * num_of_trellis_patterns + 1),
    localparam int unsigned CNT_IN_W = $clog2(width + 1)
) (
    input  logic                               i_en_correct,
    input  logic [FLAG_W-1:0]                  i_sd_flags      [width],
    input  logic [ener_bitwidth-1:0]           i_sd_flags_ener [width],
    input  logic [ener_bitwidth-1:0]           i_ener_thresh,
    input  logic [trellis_pattern_depth-2:0]   i_carry_claim,
    output logic [width-1:0]                   o_accept,
    output logic [width-1:0]                   o_drop,
    output logic [trellis_pattern_depth-2:0]   o_claim_out,
    output logic [CNT_IN_W-1:0]                o_num_accept,
    output logic [CNT_IN_W-1:0]                o_num_drop
);
    import error_gpack::*;

    localparam int unsigned D = trellis_pattern_depth;

    // Claim map over the current word plus the D-1 slots it can spill into.
    logic [width+D-2:0] w_claim;
    logic               w_free;
    logic               w_ok;

    always_comb begin
        w_claim        = '0;
        w_claim[D-2:0] = i_carry_claim;
        w_free         = 1'b0;
        w_ok           = 1'b0;
        o_accept       = '0;
        o_drop         = '0;
        o_num_accept   = '0;
        o_num_drop     = '0;
        // Position order matters: an earlier accepted window blocks later flags.
        for (int unsigned i = 0; i < width; i++) begin
            if (32'(i_sd_flags[i]) != 32'(flag_none)) begin
                w_free = (w_claim[i +: D] == '0);
                w_ok   = i_en_correct
                      && (flag_kind(32'(i_sd_flags[i]), num_of_trellis_patterns) != FLAG_KIND_BAD)
                      && (i_sd_flags_ener[i] <= i_ener_thresh)
                      && w_free;
                if (w_ok) begin
                    w_claim[i +: D] = '1;
                    o_accept[i]     = 1'b1;
                    o_num_accept    = o_num_accept + CNT_IN_W'(1);
                end else if (i_en_correct) begin
                    o_drop[i]  = 1'b1;
                    o_num_drop = o_num_drop + CNT_IN_W'(1);
                end
            end
        end
        o_claim_out = w_claim[width +: D-1];
    end

endmodule

// File: rtl/error_flag_corrector.sv
// Applies flagged trellis error patterns to a PAM4 symbol word stream.
//   clk, rstb         : clock, asynchronous active-low reset
//   valid_in          : input word valid
//   symbols_in        : PAM4 codes 0..3 per position
//   sd_flags          : flag code per position (0 none, 1..N add, N+1..2N subtract)
//   sd_flags_ener     : flag energy per position
//   trellis_patterns  : static signed error patterns [N][D]
//   ener_thresh       : largest energy at which a flag is accepted
//   en_correct        : 0 -> pass-through (pending carry is still applied)
//   clr_stats         : synchronous counter clear, wins over increments
//   valid_out         : registered word valid, one cycle after valid_in
//   symbols_out       : corrected symbols, held across invalid cycles
//   num_applied       : saturating count of accepted flags
//   num_dropped       : saturating count of dropped flags
// Windows crossing the word end are carried (offsets + claims) into the next
// valid word. Requires 2 <= trellis_pattern_depth <= width.
module error_flag_corrector #(
    parameter int unsigned width                   = 16,
    parameter int unsigned num_of_trellis_patterns = 4,
    parameter int unsigned trellis_pattern_depth   = 4,
    parameter int unsigned branch_bitwidth         = 2,
    parameter int unsigned ener_bitwidth           = error_gpack::ener_bitwidth,
    parameter int unsigned cnt_bitwidth            = 16,
    localparam int unsigned FLAG_W = $clog2(2 * num_of_trellis_patterns + 1)
) (
    input  logic                              clk,
    input  logic                              rstb,
    input  logic                              valid_in,
    input  logic        [1:0]                 symbols_in       [width],
    input  logic        [FLAG_W-1:0]          sd_flags         [width],
    input  logic        [ener_bitwidth-1:0]   sd_flags_ener    [width],
    input  logic signed [branch_bitwidth-1:0] trellis_patterns [num_of_trellis_patterns][trellis_pattern_depth],
    input  logic        [ener_bitwidth-1:0]   ener_thresh,
    input  logic                              en_correct,
    input  logic                              clr_stats,
    output logic                              valid_out,
    output logic        [1:0]                 symbols_out      [width],
    output logic        [cnt_bitwidth-1:0]    num_applied,
    output logic        [cnt_bitwidth-1:0]    num_dropped
);
    import error_gpack::*;

    localparam int unsigned D         = trellis_pattern_depth;
    localparam int unsigned CARRY_N   = D - 1;
    localparam int unsigned EXT_N     = width + CARRY_N;
    localparam int unsigned OFS_W     = branch_bitwidth + 1;
    localparam int unsigned SUM_W     = (OFS_W + 2 > sum_bitwidth_min) ? OFS_W + 2 : sum_bitwidth_min;
    localparam int unsigned CNT_IN_W  = $clog2(width + 1);
    localparam int unsigned PAT_IDX_W = (num_of_trellis_patterns > 1) ? $clog2(num_of_trellis_patterns) : 1;

    // Registered state
    logic                    r_valid;
    logic        [1:0]       r_sym       [width];
    logic signed [OFS_W-1:0] r_carry_ofs [CARRY_N];
    logic        [CARRY_N-1:0] r_carry_claim;
    logic [cnt_bitwidth-1:0] r_num_applied;
    logic [cnt_bitwidth-1:0] r_num_dropped;

    // Resolver results
    logic [width-1:0]        w_accept;
    logic [width-1:0]        w_drop;
    logic [CARRY_N-1:0]      w_claim_out;
    logic [CNT_IN_W-1:0]     w_num_accept;
    logic [CNT_IN_W-1:0]     w_num_drop;

    // Datapath
    logic signed [OFS_W-1:0] w_ofs       [EXT_N];
    logic signed [OFS_W-1:0] w_carry_ext [width];
    logic signed [SUM_W-1:0] w_sum       [width];
    logic        [1:0]       w_corr      [width];
    logic [PAT_IDX_W-1:0]    w_pat_idx;
    logic                    w_sub;
    logic signed [OFS_W-1:0] w_term;
    logic [cnt_bitwidth:0]   w_app_sum;
    logic [cnt_bitwidth:0]   w_drp_sum;
    logic [cnt_bitwidth-1:0] w_app_next;
    logic [cnt_bitwidth-1:0] w_drp_next;

    flag_window_resolver #(
        .width                   (width),
        .num_of_trellis_patterns (num_of_trellis_patterns),
        .trellis_pattern_depth   (trellis_pattern_depth),
        .ener_bitwidth           (ener_bitwidth)
    ) u_resolver (
        .i_en_correct    (en_correct),
        .i_sd_flags      (sd_flags),
        .i_sd_flags_ener (sd_flags_ener),
        .i_ener_thresh   (ener_thresh),
        .i_carry_claim   (r_carry_claim),
        .o_accept        (w_accept),
        .o_drop          (w_drop),
        .o_claim_out     (w_claim_out),
        .o_num_accept    (w_num_accept),
        .o_num_drop      (w_num_drop)
    );

    // Per-position offsets from accepted windows, including the spill slots.
    always_comb begin
        w_pat_idx = '0;
        w_sub     = 1'b0;
        w_term    = '0;
        for (int unsigned p = 0; p < EXT_N; p++)
            w_ofs[p] = '0;
        for (int unsigned i = 0; i < width; i++) begin
            if (w_accept[i]) begin
                w_pat_idx = PAT_IDX_W'(flag_pattern_index(32'(sd_flags[i]), num_of_trellis_patterns));
                w_sub     = (flag_kind(32'(sd_flags[i]), num_of_trellis_patterns) == FLAG_KIND_SUB);
                for (int unsigned j = 0; j < D; j++) begin
                    w_term       = OFS_W'(trellis_patterns[w_pat_idx][j]);
                    w_ofs[i + j] = w_ofs[i + j] + (w_sub ? -w_term : w_term);
                end
            end
        end
    end

    // Symbol + carry + current offset, saturated to 0..3.
    always_comb begin
        for (int unsigned p = 0; p < width; p++)
            w_carry_ext[p] = '0;
        for (int unsigned q = 0; q < CARRY_N; q++)
            w_carry_ext[q] = r_carry_ofs[q];
        for (int unsigned p = 0; p < width; p++) begin
            w_sum[p] = $signed(SUM_W'({1'b0, symbols_in[p]}))
                     + SUM_W'(w_carry_ext[p])
                     + SUM_W'(w_ofs[p]);
            if (w_sum[p][SUM_W-1])
                w_corr[p] = 2'd0;
            else if (w_sum[p][SUM_W-2:2] != '0)
                w_corr[p] = 2'd3;
            else
                w_corr[p] = w_sum[p][1:0];
        end
    end

    // Saturating counter updates.
    always_comb begin
        w_app_sum  = {1'b0, r_num_applied} + (cnt_bitwidth + 1)'(w_num_accept);
        w_drp_sum  = {1'b0, r_num_dropped} + (cnt_bitwidth + 1)'(w_num_drop);
        w_app_next = w_app_sum[cnt_bitwidth] ? '1 : w_app_sum[cnt_bitwidth-1:0];
        w_drp_next = w_drp_sum[cnt_bitwidth] ? '1 : w_drp_sum[cnt_bitwidth-1:0];
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_valid       <= 1'b0;
            r_carry_claim <= '0;
            r_num_applied <= '0;
            r_num_dropped <= '0;
            for (int unsigned p = 0; p < width; p++)
                r_sym[p] <= '0;
            for (int unsigned q = 0; q < CARRY_N; q++)
                r_carry_ofs[q] <= '0;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                for (int unsigned p = 0; p < width; p++)
                    r_sym[p] <= w_corr[p];
                for (int unsigned q = 0; q < CARRY_N; q++)
                    r_carry_ofs[q] <= w_ofs[width + q];
                r_carry_claim <= w_claim_out;
            end
            if (clr_stats) begin
                r_num_applied <= '0;
                r_num_dropped <= '0;
            end else if (valid_in) begin
                r_num_applied <= w_app_next;
                r_num_dropped <= w_drp_next;
            end
        end
    end

    assign valid_out   = r_valid;
    assign symbols_out = r_sym;
    assign num_applied = r_num_applied;
    assign num_dropped = r_num_dropped;

    // Dropped mask is only consumed through its count.
    logic w_unused;
    assign w_unused = ^w_drop;

endmodule

// File: tb/tb_error_flag_corrector.sv
// Directed-vector bench for error_flag_corrector (default parameters).
module tb_error_flag_corrector;

    logic              clk = 1'b0;
    logic              rstb;
    logic              valid_in;
    logic        [1:0] symbols_in       [16];
    logic        [3:0] sd_flags         [16];
    logic        [7:0] sd_flags_ener    [16];
    logic signed [1:0] trellis_patterns [4][4];
    logic        [7:0] ener_thresh;
    logic              en_correct;
    logic              clr_stats;
    logic              valid_out;
    logic        [1:0] symbols_out      [16];
    logic       [15:0] num_applied;
    logic       [15:0] num_dropped;

    int n_checks = 0;
    int n_errors = 0;

    error_flag_corrector dut (
        .clk              (clk),
        .rstb             (rstb),
        .valid_in         (valid_in),
        .symbols_in       (symbols_in),
        .sd_flags         (sd_flags),
        .sd_flags_ener    (sd_flags_ener),
        .trellis_patterns (trellis_patterns),
        .ener_thresh      (ener_thresh),
        .en_correct       (en_correct),
        .clr_stats        (clr_stats),
        .valid_out        (valid_out),
        .symbols_out      (symbols_out),
        .num_applied      (num_applied),
        .num_dropped      (num_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fill(input logic [1:0] s);
        logic [31:0] w;
        for (int p = 0; p < 16; p++) w[2*p +: 2] = s;
        return w;
    endfunction

    function automatic logic [31:0] put(input logic [31:0] w, input int p, input logic [1:0] s);
        logic [31:0] r;
        r = w;
        r[2*p +: 2] = s;
        return r;
    endfunction

    function automatic logic [31:0] outw();
        logic [31:0] w;
        for (int p = 0; p < 16; p++) w[2*p +: 2] = symbols_out[p];
        return w;
    endfunction

    task automatic load(input logic [1:0] s);
        for (int p = 0; p < 16; p++) begin
            symbols_in[p]    = s;
            sd_flags[p]      = 4'd0;
            sd_flags_ener[p] = 8'd0;
        end
    endtask

    task automatic push();
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [31:0] exp_sym,
                              input int exp_app, input int exp_drp);
        check({tag, "_valid"}, 32'(valid_out), 32'd1);
        check({tag, "_sym"}, outw(), exp_sym);
        check({tag, "_applied"}, 32'(num_applied), 32'(exp_app));
        check({tag, "_dropped"}, 32'(num_dropped), 32'(exp_drp));
    endtask

    initial begin
        rstb        = 1'b1;
        valid_in    = 1'b0;
        en_correct  = 1'b1;
        clr_stats   = 1'b0;
        ener_thresh = 8'hFF;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                trellis_patterns[k][j] = 2'sd0;
        trellis_patterns[0][0] = 2'sd1;
        trellis_patterns[0][1] = -2'sd1;
        for (int j = 0; j < 4; j++) trellis_patterns[1][j] = 2'sd1;
        trellis_patterns[2][0] = -2'sd1;
        trellis_patterns[3][1] = 2'sd1;
        load(2'd0);

        #3 rstb = 1'b0;
        #1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_sym", outw(), 32'd0);
        check("rst_applied", 32'(num_applied), 32'd0);
        check("rst_dropped", 32'(num_dropped), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rstb = 1'b1;

        // No flags: pass-through
        load(2'd2);
        push();
        check_word("v1", fill(2'd2), 0, 0);

        // Add pattern0 at 3 on all-1
        load(2'd1);
        sd_flags[3] = 4'd1;
        push();
        check_word("v2", put(put(fill(2'd1), 3, 2'd2), 4, 2'd0), 1, 0);

        // Subtract pattern1 at 14: spills two slots into the next word
        load(2'd2);
        sd_flags[14] = 4'd6;
        push();
        check_word("v3", put(put(fill(2'd2), 14, 2'd1), 15, 2'd1), 2, 0);

        // Idle cycle: output held, carry kept
        @(posedge clk);
        #1;
        check("idle_valid", 32'(valid_out), 32'd0);
        check("idle_sym", outw(), put(put(fill(2'd2), 14, 2'd1), 15, 2'd1));

        load(2'd2);
        push();
        check_word("v4", put(put(fill(2'd2), 0, 2'd1), 1, 2'd1), 2, 0);

        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        check("clr_applied", 32'(num_applied), 32'd0);
        check("clr_dropped", 32'(num_dropped), 32'd0);
        check("clr_sym_hold", outw(), put(put(fill(2'd2), 0, 2'd1), 1, 2'd1));

        // Overlapping windows: 5 accepted, 7 dropped
        load(2'd1);
        sd_flags[5] = 4'd2;
        sd_flags[7] = 4'd2;
        push();
        check_word("v5", put(put(put(put(fill(2'd1), 5, 2'd2), 6, 2'd2), 7, 2'd2), 8, 2'd2), 1, 1);

        // Energy above threshold dropped, invalid code dropped, energy == threshold accepted
        ener_thresh = 8'd100;
        load(2'd1);
        sd_flags[0] = 4'd2;  sd_flags_ener[0]  = 8'd200;
        sd_flags[8] = 4'd9;
        sd_flags[12] = 4'd1; sd_flags_ener[12] = 8'd100;
        push();
        check_word("v6", put(put(fill(2'd1), 12, 2'd2), 13, 2'd0), 2, 3);
        ener_thresh = 8'hFF;

        // Carry survives en_correct going low
        load(2'd2);
        sd_flags[14] = 4'd6;
        push();
        check_word("va", put(put(fill(2'd2), 14, 2'd1), 15, 2'd1), 3, 3);
        en_correct = 1'b0;
        load(2'd2);
        sd_flags[5] = 4'd1;
        push();
        check_word("vb", put(put(fill(2'd2), 0, 2'd1), 1, 2'd1), 3, 3);
        en_correct = 1'b1;

        // Saturation at 0 and at 3
        load(2'd0);
        sd_flags[2]  = 4'd5;
        sd_flags[10] = 4'd2;
        push();
        check_word("vc", put(put(put(put(put(fill(2'd0), 3, 2'd1), 10, 2'd1), 11, 2'd1), 12, 2'd1), 13, 2'd1), 5, 3);
        load(2'd3);
        sd_flags[0] = 4'd2;
        push();
        check_word("vd", fill(2'd3), 6, 3);

        // Reset between a boundary-crossing word and the next word
        load(2'd2);
        sd_flags[14] = 4'd6;
        push();
        check_word("ve", put(put(fill(2'd2), 14, 2'd1), 15, 2'd1), 7, 3);
        #2 rstb = 1'b0;
        #1;
        check("mrst_valid", 32'(valid_out), 32'd0);
        check("mrst_sym", outw(), 32'd0);
        check("mrst_applied", 32'(num_applied), 32'd0);
        check("mrst_dropped", 32'(num_dropped), 32'd0);
        load(2'd2);
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_valid_held", 32'(valid_out), 32'd0);
        valid_in = 1'b0;
        @(negedge clk) rstb = 1'b1;
        load(2'd2);
        push();
        check_word("vf", fill(2'd2), 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/error_flag_corrector.md
# error_flag_corrector

Consumes the per-position flags, flag energies and delayed symbols produced by `error_checker_datapath` and applies the flagged trellis error patterns to the symbol stream. The result is corrected PAM4 symbol words. Flag windows that cross a word boundary are carried into the next word. The block sits directly downstream of the error checker, in front of the PRBS checker and the symbol sink.

## Interface
Parameters:
- `width`, 16: symbols per word
- `num_of_trellis_patterns`, 4: number of patterns (N)
- `trellis_pattern_depth`, 4: pattern length (D), must satisfy D ≤ `width`
- `branch_bitwidth`, 2: signed pattern element width
- `ener_bitwidth`, `error_gpack::ener_bitwidth`: flag energy width
- `cnt_bitwidth`, 16: width of the statistics counters

Ports (clock and reset first; one clock; reset is asynchronous and active-low):
- `clk`, in, 1: clock
- `rstb`, in, 1: asynchronous active-low reset
- `valid_in`, in, 1: input word valid
- `symbols_in[width]`, in, 2 each: PAM4 codes 0..3
- `sd_flags[width]`, in, $clog2(2N+1) each: flag per position
- `sd_flags_ener[width]`, in, `ener_bitwidth` each: flag energies
- `trellis_patterns[N][D]`, in, `branch_bitwidth` signed: static patterns
- `ener_thresh`, in, `ener_bitwidth`: maximum energy at which a flag is accepted
- `en_correct`, in, 1: 0 disables correction (pass-through)
- `clr_stats`, in, 1: synchronous clear of counters
- `valid_out`, out, 1: output word valid
- `symbols_out[width]`, out, 2 each: corrected symbols
- `num_applied`, out, `cnt_bitwidth`: saturating count of applied flags
- `num_dropped`, out, `cnt_bitwidth`: saturating count of dropped flags

## Operation
- Flag code f: 0 means no flag. 1..N means add pattern f-1 (sign +1). N+1..2N means subtract pattern f-N-1 (sign -1). Codes above 2N are invalid.
- A flag at position i accepted as pattern k with sign s modifies position i+j by s·pattern[k][j], for j = 0..D-1.
  - Index 0 applies to the flagged position.
  - Element j lands in the current word if i+j < `width`, else in carry slot i+j-`width` of the next word.
- Acceptance is resolved greedily from position 0 upward. A nonzero flag is accepted only if all of the following hold:
  - `en_correct`=1
  - code ≤ 2N
  - energy ≤ `ener_thresh`
  - its window does not overlap a window already claimed in this word or claimed by carry from the previous word
- A nonzero flag that is not accepted is counted as dropped. When `en_correct`=0, no flags are counted at all.
- Arithmetic: the symbol, the carry contribution and the current-word contribution are summed in signed width ≥ 5. The result saturates to 0..3.
- Carry register: D-1 signed offsets plus D-1 claim bits.
  - Loaded only on cycles with `valid_in`=1.
  - Consumed by the next valid word.
  - Held unchanged across invalid cycles.
- Counters increment by the number of accepted (or dropped) flags in the word and saturate at all-ones. `clr_stats` takes priority over increments on the same cycle.

## Timing
- Latency: 1 cycle. On `valid_in`=1 at edge n, the corrected word and `valid_out`=1 appear after edge n.
- `valid_in`=0: `valid_out`=0, `symbols_out` holds its last value, and carry and counters are unchanged.
- Reset (asynchronous, any time including mid-stream): `valid_out`=0, `symbols_out` all 0, carry and claims 0, counters 0. The first word after reset sees no carry.
- Toggling `en_correct` to 0 does not flush a pending carry. The carry is still applied to the next valid word.

## Structure
- `error_gpack` gains:
  - a flag-code typedef
  - `flag_none` = 0
  - helper constants for the sign split at N
- A combinational sub-module `flag_window_resolver` performs greedy acceptance and claim generation. The top level holds the registers, the carry and the counters.

## Test plan
Unless stated otherwise: N=4, D=4, pattern0 = {1,-1,0,0}, pattern1 = {1,1,1,1}, `ener_thresh` = max.
- No flags, symbols all 2 -> output all 2 one cycle later; counters stay 0.
- Flag 1 at position 3, symbols all 1 -> positions 3 and 4 become 2 and 0; `num_applied`=1.
- Flag 6 at position 14, symbols all 2, next word all 2 with no flags -> word0 positions 14 and 15 become 1; word1 positions 0 and 1 become 1.
- Flags 2 at positions 5 and 7 -> position 5 accepted, position 7 dropped; `num_applied`=1, `num_dropped`=1.
- Flag 2 at position 0 with energy above `ener_thresh` -> symbols unchanged; `num_dropped`=1. Flag code 9 -> dropped.
- `rstb` pulsed low between a boundary-crossing word and the next word -> the next word is output uncorrected and `valid_out` is 0 during reset.
